// File: rtl/mux16_scan_ctrl.sv
// mux16_scan_ctrl
// Word-to-bit serializer built around an external combinational 16:1 mux.
// A 16-bit word is accepted over valid/ready and held on the mux data bus.
// The mux select then steps once per accepted bit. The mux output comes back
// as a valid/ready bit stream that carries a last-bit flag.

module mux16_scan_ctrl #(
    parameter int MSB_FIRST = 0,
    parameter int GAP       = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] word_in,
    input  logic        word_valid,
    output logic        word_ready,
    output logic [15:0] mux_data,
    output logic [3:0]  mux_sel,
    input  logic        mux_y,
    output logic        bit_out,
    output logic        bit_valid,
    input  logic        bit_ready,
    output logic        bit_last,
    output logic        busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    // The select starts at the end of the word that is shifted out first.
    localparam logic [3:0] SEL_START = (MSB_FIRST != 0) ? 4'd15 : 4'd0;
    localparam bit         HAS_GAP   = (GAP > 0);
    localparam logic [2:0] GAP_LAST  = 3'((GAP > 0) ? (GAP - 1) : 0);

    state_t      r_state;
    state_t      w_next;
    logic [15:0] r_muxData;
    logic [3:0]  r_muxSel;
    logic [3:0]  r_cnt;
    logic [2:0]  r_gapCnt;

    logic        w_accept;
    logic        w_bitFire;
    logic        w_lastBit;
    logic [3:0]  w_selStep;

    assign w_accept  = (r_state == ST_IDLE) && word_valid;
    assign w_bitFire = (r_state == ST_SCAN) && bit_ready;
    assign w_lastBit = (r_cnt == 4'd15);
    assign w_selStep = (MSB_FIRST != 0) ? (r_muxSel - 4'd1) : (r_muxSel + 4'd1);

    // State register: an asynchronous reset drops any partial word at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic. A word ends on the handshake of its 16th bit.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (word_valid) begin
                    w_next = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (bit_ready && w_lastBit) begin
                    w_next = HAS_GAP ? ST_GAP : ST_IDLE;
                end
            end
            ST_GAP: begin
                if (r_gapCnt == GAP_LAST) begin
                    w_next = ST_IDLE;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Datapath: the word is held, and the select advances only on bit handshakes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_muxData <= 16'd0;
            r_muxSel  <= SEL_START;
            r_cnt     <= 4'd0;
            r_gapCnt  <= 3'd0;
        end else if (w_accept) begin
            r_muxData <= word_in;
            r_muxSel  <= SEL_START;
            r_cnt     <= 4'd0;
        end else if (w_bitFire) begin
            if (w_lastBit) begin
                r_muxSel <= SEL_START;
                r_cnt    <= 4'd0;
                r_gapCnt <= 3'd0;
            end else begin
                r_muxSel <= w_selStep;
                r_cnt    <= r_cnt + 4'd1;
            end
        end else if (r_state == ST_GAP) begin
            r_gapCnt <= r_gapCnt + 3'd1;
        end
    end

    // Output decode: handshake flags depend only on the state. The serial bit is the mux output itself.
    always_comb begin
        word_ready = (r_state == ST_IDLE);
        bit_valid  = (r_state == ST_SCAN);
        bit_last   = (r_state == ST_SCAN) && w_lastBit;
        busy       = (r_state != ST_IDLE);
        bit_out    = mux_y;
    end

    assign mux_data = r_muxData;
    assign mux_sel  = r_muxSel;

endmodule

// File: tb/tb_mux16_scan_ctrl.sv
// Directed bench for mux16_scan_ctrl. Three configurations share one set of
// inputs: LSB-first/no gap, MSB-first/no gap, and LSB-first/gap of 3.
// A behavioural 16:1 mux closes the loop for each configuration.

module tb_mux16_scan_ctrl;

    logic        clk;
    logic        rst_n;
    logic [15:0] word_in;
    logic        word_valid;
    logic        bit_ready;

    logic        word_ready0, word_ready1, word_ready2;
    logic [15:0] mux_data0, mux_data1, mux_data2;
    logic [3:0]  mux_sel0, mux_sel1, mux_sel2;
    logic        mux_y0, mux_y1, mux_y2;
    logic        bit_out0, bit_out1, bit_out2;
    logic        bit_valid0, bit_valid1, bit_valid2;
    logic        bit_last0, bit_last1, bit_last2;
    logic        busy0, busy1, busy2;

    int checks;
    int failures;
    int hs;
    int cyc;

    // External 16:1 muxes, one for each configuration
    assign mux_y0 = mux_data0[mux_sel0];
    assign mux_y1 = mux_data1[mux_sel1];
    assign mux_y2 = mux_data2[mux_sel2];

    mux16_scan_ctrl #(.MSB_FIRST(0), .GAP(0)) u0 (
        .clk(clk), .rst_n(rst_n), .word_in(word_in), .word_valid(word_valid),
        .word_ready(word_ready0), .mux_data(mux_data0), .mux_sel(mux_sel0),
        .mux_y(mux_y0), .bit_out(bit_out0), .bit_valid(bit_valid0),
        .bit_ready(bit_ready), .bit_last(bit_last0), .busy(busy0)
    );

    mux16_scan_ctrl #(.MSB_FIRST(1), .GAP(0)) u1 (
        .clk(clk), .rst_n(rst_n), .word_in(word_in), .word_valid(word_valid),
        .word_ready(word_ready1), .mux_data(mux_data1), .mux_sel(mux_sel1),
        .mux_y(mux_y1), .bit_out(bit_out1), .bit_valid(bit_valid1),
        .bit_ready(bit_ready), .bit_last(bit_last1), .busy(busy1)
    );

    mux16_scan_ctrl #(.MSB_FIRST(0), .GAP(3)) u2 (
        .clk(clk), .rst_n(rst_n), .word_in(word_in), .word_valid(word_valid),
        .word_ready(word_ready2), .mux_data(mux_data2), .mux_sel(mux_sel2),
        .mux_y(mux_y2), .bit_out(bit_out2), .bit_valid(bit_valid2),
        .bit_ready(bit_ready), .bit_last(bit_last2), .busy(busy2)
    );

    // Free-running clock with a 10-unit period
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compare one observed value against the value the bench expects
    task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive the shared input bus
    task automatic applyStimulus(input logic [15:0] w, input logic v, input logic r);
        word_in    = w;
        word_valid = v;
        bit_ready  = r;
    endtask

    // Advance to 2 time units after the next rising edge, where the outputs are stable
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Assert reset, then release it away from the active edge
    task automatic doReset();
        rst_n = 1'b0;
        applyStimulus(16'h0000, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    // Check 16 back-to-back LSB-first bits from u0 with bit_ready held high
    task automatic scanCheck0(input string tag, input logic [15:0] w);
        for (int i = 0; i < 16; i++) begin
            checkOutput({tag, "_valid"}, 16'(bit_valid0), 16'd1);
            checkOutput({tag, "_bit"}, 16'(bit_out0), 16'(w[i]));
            checkOutput({tag, "_sel"}, 16'(mux_sel0), 16'(i));
            checkOutput({tag, "_last"}, 16'(bit_last0), (i == 15) ? 16'd1 : 16'd0);
            checkOutput({tag, "_data"}, mux_data0, w);
            tick();
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        applyStimulus(16'h0000, 1'b0, 1'b0);
        doReset();

        // Reset values
        checkOutput("rst_ready0", 16'(word_ready0), 16'd1);
        checkOutput("rst_valid0", 16'(bit_valid0), 16'd0);
        checkOutput("rst_last0", 16'(bit_last0), 16'd0);
        checkOutput("rst_busy0", 16'(busy0), 16'd0);
        checkOutput("rst_sel0", 16'(mux_sel0), 16'd0);
        checkOutput("rst_data0", mux_data0, 16'h0000);
        checkOutput("rst_sel1", 16'(mux_sel1), 16'd15);

        // Reset asserted mid-word takes effect without a clock edge
        applyStimulus(16'h1234, 1'b1, 1'b1);
        tick();
        applyStimulus(16'h1234, 1'b0, 1'b1);
        tick();
        tick();
        checkOutput("t1_pre_valid0", 16'(bit_valid0), 16'd1);
        checkOutput("t1_pre_sel0", 16'(mux_sel0), 16'd2);
        rst_n = 1'b0;
        #1;
        checkOutput("t1_valid0", 16'(bit_valid0), 16'd0);
        checkOutput("t1_ready0", 16'(word_ready0), 16'd1);
        checkOutput("t1_sel0", 16'(mux_sel0), 16'd0);
        checkOutput("t1_last0", 16'(bit_last0), 16'd0);
        checkOutput("t1_busy0", 16'(busy0), 16'd0);
        checkOutput("t1_data0", mux_data0, 16'h0000);
        checkOutput("t1_sel1", 16'(mux_sel1), 16'd15);
        doReset();

        // LSB-first serialization of A5C3. The GAP=3 instance also runs this word.
        applyStimulus(16'hA5C3, 1'b1, 1'b1);
        checkOutput("t2_ready0", 16'(word_ready0), 16'd1);
        tick();
        applyStimulus(16'h0000, 1'b0, 1'b1);
        scanCheck0("t2", 16'hA5C3);
        checkOutput("t2_ready_after17", 16'(word_ready0), 16'd1);
        checkOutput("t2_busy_after17", 16'(busy0), 16'd0);
        checkOutput("t2_valid_after17", 16'(bit_valid0), 16'd0);
        checkOutput("t2_sel_home", 16'(mux_sel0), 16'd0);

        // GAP=3: word_ready stays low for 3 cycles after the last handshake
        for (int g = 0; g < 3; g++) begin
            checkOutput("t6_gap_ready2", 16'(word_ready2), 16'd0);
            checkOutput("t6_gap_busy2", 16'(busy2), 16'd1);
            checkOutput("t6_gap_valid2", 16'(bit_valid2), 16'd0);
            checkOutput("t6_gap_last2", 16'(bit_last2), 16'd0);
            tick();
        end
        checkOutput("t6_ready2", 16'(word_ready2), 16'd1);
        checkOutput("t6_busy2", 16'(busy2), 16'd0);
        doReset();

        // MSB-first serialization of 8001
        applyStimulus(16'h8001, 1'b1, 1'b1);
        tick();
        applyStimulus(16'h0000, 1'b0, 1'b1);
        for (int i = 0; i < 16; i++) begin
            checkOutput("t3_valid1", 16'(bit_valid1), 16'd1);
            checkOutput("t3_bit1", 16'(bit_out1), (i == 0 || i == 15) ? 16'd1 : 16'd0);
            checkOutput("t3_sel1", 16'(mux_sel1), 16'(15 - i));
            checkOutput("t3_last1", 16'(bit_last1), (i == 15) ? 16'd1 : 16'd0);
            tick();
        end
        checkOutput("t3_ready1", 16'(word_ready1), 16'd1);
        checkOutput("t3_sel1_home", 16'(mux_sel1), 16'd15);
        doReset();

        // Backpressure with a random bit_ready. The first cycle always stalls.
        applyStimulus(16'hFFFE, 1'b1, 1'b0);
        tick();
        applyStimulus(16'h0000, 1'b0, 1'b0);
        hs  = 0;
        cyc = 0;
        while (word_ready0 == 1'b0 && cyc < 300) begin
            bit_ready = (cyc == 0) ? 1'b0 : 1'($urandom_range(0, 1));
            #1;
            checkOutput("t4_valid", 16'(bit_valid0), 16'd1);
            checkOutput("t4_bit", 16'(bit_out0), (hs == 0) ? 16'd0 : 16'd1);
            checkOutput("t4_sel", 16'(mux_sel0), 16'(hs & 15));
            checkOutput("t4_last", 16'(bit_last0), (hs == 15) ? 16'd1 : 16'd0);
            if (bit_ready) hs++;
            tick();
            cyc++;
        end
        checkOutput("t4_handshakes", 16'(hs), 16'd16);
        checkOutput("t4_ready", 16'(word_ready0), 16'd1);
        doReset();

        // word_valid held high: the new word_in is ignored during SCAN, and the next word follows after one bubble
        applyStimulus(16'h3C5A, 1'b1, 1'b1);
        tick();
        applyStimulus(16'h0F0F, 1'b1, 1'b1);
        scanCheck0("t5a", 16'h3C5A);
        checkOutput("t5_bubble_valid", 16'(bit_valid0), 16'd0);
        checkOutput("t5_bubble_ready", 16'(word_ready0), 16'd1);
        tick();
        applyStimulus(16'h0000, 1'b0, 1'b1);
        scanCheck0("t5b", 16'h0F0F);
        checkOutput("t5_end_ready", 16'(word_ready0), 16'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
